inst_loader: RTL

Boot-time instruction loader and instruction memory that sits directly upstream of the OpenMIPS core's fetch port. It accepts a byte stream (word count header plus big-endian instruction words) on a valid/ready interface and writes it into an internal instruction RAM while holding the core in reset. Once the load completes, it releases the core and serves `rom_data` for the core's `rom_ce`/`rom_addr` fetches with zero-latency (same-cycle) reads.

---
 rtl/inst_loader.sv | 100 ++++++++++
 1 files changed

// File: rtl/inst_loader.sv
// Boot-time instruction loader: takes a count header plus big-endian words from a
// byte stream, fills the instruction RAM with the core held in reset, then serves fetches.
module inst_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid_i,
  input  logic [7:0]            ld_data_i,
  output logic                  ld_ready_o,
  input  logic                  rom_ce_i,
  input  logic [31:0]           rom_addr_i,
  output logic [31:0]           rom_data_o,
  output logic                  core_rst_o,
  output logic                  loaded_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH:0]   words_o
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, RUN, ERR} state_t;

  state_t                state_q, state_d;
  logic [15:0]           count_q;
  logic [1:0]            byte_q;
  logic [23:0]           asm_q;
  logic [ADDR_WIDTH:0]   words_q, words_inc;
  logic [31:0]           mem [DEPTH];
  logic                  xfer, word_done, last_word;
  logic [16:0]           hdr_cnt;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  rd_hit;
  logic                  unused_addr_bits;

  assign ld_ready_o = (state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == DATA);
  assign xfer       = ld_valid_i & ld_ready_o;
  // Full header value as seen on the HDR_LO edge, widened so DEPTH itself is representable.
  assign hdr_cnt    = {1'b0, count_q[15:8], ld_data_i};
  assign words_inc  = words_q + 1'b1;
  assign word_done  = xfer && (state_q == DATA) && (byte_q == 2'd3);
  assign last_word  = (32'(words_inc) == 32'(count_q));

  always_comb begin
    state_d = state_q;
    if (xfer) begin
      case (state_q)
        HDR_HI: state_d = HDR_LO;
        HDR_LO: begin
          if (hdr_cnt == 17'd0)             state_d = RUN;
          else if (hdr_cnt > 17'(DEPTH))    state_d = ERR;
          else                              state_d = DATA;
        end
        DATA:    if (word_done && last_word) state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= HDR_HI;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      byte_q  <= '0;
      asm_q   <= '0;
      words_q <= '0;
    end else if (xfer) begin
      case (state_q)
        HDR_HI: count_q[15:8] <= ld_data_i;
        HDR_LO: count_q[7:0]  <= ld_data_i;
        DATA: begin
          byte_q <= byte_q + 2'd1;
          asm_q  <= {asm_q[15:0], ld_data_i};
          if (byte_q == 2'd3) words_q <= words_inc;
        end
        default: ;
      endcase
    end
  end

  // RAM has no reset; stale contents are masked by the words_o bound on reads.
  always_ff @(posedge clk) begin
    if (word_done) mem[words_q[ADDR_WIDTH-1:0]] <= {asm_q, ld_data_i};
  end

  assign rd_idx = rom_addr_i[ADDR_WIDTH+1:2];
  assign rd_hit = rom_ce_i && (state_q == RUN) &&
                  (rom_addr_i[31:ADDR_WIDTH+2] == '0) &&
                  ({1'b0, rd_idx} < words_q);
  assign rom_data_o = rd_hit ? mem[rd_idx] : 32'h0;
  assign unused_addr_bits = ^rom_addr_i[1:0];

  assign core_rst_o = (state_q != RUN);
  assign loaded_o   = (state_q == RUN);
  assign err_o      = (state_q == ERR);
  assign words_o    = words_q;
endmodule
